// File: rtl/sysid_pkg.sv
// Shared definitions for the sysid checker: FSM encoding, slave word
// addresses and the default expected ID/timestamp words.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h5E5A_1B1E;

    function automatic logic is_rd(state_t s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

    function automatic logic is_wt(state_t s);
        return (s == WT_ID) || (s == WT_TS);
    endfunction

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read channel between the checker (master) and a sysid slave.
// Signals: address, read (master out); waitrequest, readdatavalid, readdata (slave out).
interface sysid_checker_if;

    logic        address;
    logic        read;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdatavalid,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdatavalid,
        output readdata
    );

endinterface

// File: rtl/sysid_timeout_ctr.sv
// Per-transaction cycle counter; expired is high once the count hits TIMEOUT_CYCLES-1.
// Ports: clock, reset, clear (restart at 0), enable (count this cycle), expired.
module sysid_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // Saturates at LAST so expired stays asserted until cleared.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid ID (addr 0) and timestamp (addr 1) words and compares them.
// Ports: clock, reset, start, bus (Avalon-MM master), status flags, captured words.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    sysid_checker_if.master bus,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            id_ok,
    output logic            ts_ok,
    output logic            timeout,
    output logic [31:0]     id_value,
    output logic [31:0]     ts_value
);

    state_t state;
    state_t state_next;
    logic   after_reset;
    logic   expired;
    logic   capture;
    logic   id_cap;
    logic   ts_cap;
    logic   to_hit;

    // Data is taken in WT_* or in an RD_* accept cycle that already has valid.
    assign capture = bus.readdatavalid &&
                     (is_wt(state) || (is_rd(state) && !bus.waitrequest));
    assign id_cap  = capture && (state == RD_ID || state == WT_ID);
    assign ts_cap  = capture && (state == RD_TS || state == WT_TS);
    // Only a timeout leaves a transaction state straight for DONE.
    assign to_hit  = (is_rd(state) || is_wt(state)) && state_next == DONE;

    sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctr (
        .clock  (clock),
        .reset  (reset),
        .clear  (is_rd(state_next) && state_next != state),
        .enable (is_rd(state) || is_wt(state)),
        .expired(expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start || (AUTO_START && after_reset)) state_next = RD_ID;
            end
            RD_ID: begin
                if (capture)               state_next = RD_TS;
                else if (expired)          state_next = DONE;
                else if (!bus.waitrequest) state_next = WT_ID;
            end
            WT_ID: begin
                if (capture)      state_next = RD_TS;
                else if (expired) state_next = DONE;
            end
            RD_TS: begin
                if (capture)               state_next = CHECK;
                else if (expired)          state_next = DONE;
                else if (!bus.waitrequest) state_next = WT_TS;
            end
            WT_TS: begin
                if (capture)      state_next = CHECK;
                else if (expired) state_next = DONE;
            end
            CHECK: state_next = DONE;
            DONE: begin
                if (start) state_next = RD_ID;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.read    = 1'b0;
        bus.address = ADDR_ID;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state)
            IDLE:  busy = 1'b0;
            RD_ID: bus.read = 1'b1;
            RD_TS: begin
                bus.read    = 1'b1;
                bus.address = ADDR_TS;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            after_reset <= 1'b1;
            id_value    <= '0;
            ts_value    <= '0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            after_reset <= 1'b0;
            if (id_cap) id_value <= bus.readdata;
            if (ts_cap) ts_value <= bus.readdata;
            if (state == DONE && start) begin
                pass    <= 1'b0;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (state == CHECK) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TS);
                pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
            end
            if (to_hit) begin
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a configurable Avalon-MM sysid slave.
// Ports: none; drives clock/reset/start and the slave side of the interface.
module tb_sysid_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Slave configuration and state
    int          n_wait      = 0;
    int          lat         = 0;
    bit          never_valid = 1'b0;
    bit          spur        = 1'b0;
    logic [31:0] data_id     = 32'h0000_0000;
    logic [31:0] data_ts     = 32'h5E5A_1B1E;
    int          wcnt        = 0;
    int          pend        = 0;
    logic        addr_q      = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sysid_checker_if bus();

    sysid_checker dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .id_ok   (id_ok),
        .ts_ok   (ts_ok),
        .timeout (timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    assign bus.waitrequest   = bus.read && (wcnt < n_wait);
    assign bus.readdatavalid = spur || (!never_valid &&
        ((lat == 0) ? (bus.read && !bus.waitrequest) : (pend == 1)));
    assign bus.readdata = spur ? 32'hDEAD_BEEF :
        (((lat == 0) ? bus.address : addr_q) ? data_ts : data_id);

    always @(posedge clock) begin
        if (reset) begin
            wcnt <= 0;
            pend <= 0;
        end else begin
            if (pend > 0) pend <= pend - 1;
            if (bus.read && bus.waitrequest) begin
                wcnt <= wcnt + 1;
            end else if (bus.read) begin
                wcnt   <= 0;
                pend   <= lat;
                addr_q <= bus.address;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {24'd0, bus.read, bus.address, busy, done,
                pass, id_ok, ts_ok, timeout};
    endfunction

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (done) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int exp_addr;
        int stalls;
        int reads;
        int accepts;
        int entries;
        bit prev;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_flags", flags(), 32'd0);
        check("rst_id", id_value, 32'd0);
        check("rst_ts", ts_value, 32'd0);

        // Auto start, zero-wait slave, matching words
        reset = 1'b0;
        t0    = cyc;
        wait_done(40);
        check("auto_lat", cyc - t0, 32'd4);
        check("auto_pass", pass, 1'b1);
        check("auto_id_ok", id_ok, 1'b1);
        check("auto_ts_ok", ts_ok, 1'b1);
        check("auto_to", timeout, 1'b0);
        check("auto_ts_val", ts_value, 32'h5E5A_1B1E);
        check("auto_idle", {bus.read, busy}, 32'd0);

        // Spurious valid in DONE is ignored, results hold
        spur = 1'b1;
        repeat (2) @(negedge clock);
        spur = 1'b0;
        @(negedge clock);
        check("hold_done", done, 1'b1);
        check("hold_pass", pass, 1'b1);
        check("spur_id", id_value, 32'd0);
        check("spur_ts", ts_value, 32'h5E5A_1B1E);

        // Wrong timestamp word, restart from DONE clears flags
        data_ts = 32'h5E5A_1B1F;
        start   = 1'b1;
        t0      = cyc;
        @(negedge clock);
        start = 1'b0;
        check("clr_done", done, 1'b0);
        check("clr_pass", pass, 1'b0);
        check("clr_busy", busy, 1'b1);
        wait_done(40);
        check("bad_lat", cyc - t0, 32'd4);
        check("bad_id_ok", id_ok, 1'b1);
        check("bad_ts_ok", ts_ok, 1'b0);
        check("bad_pass", pass, 1'b0);
        check("bad_ts_val", ts_value, 32'h5E5A_1B1F);

        // Stalling slave: 3 wait cycles, valid 2 cycles after accept
        data_ts = 32'h5E5A_1B1E;
        n_wait  = 3;
        lat     = 2;
        start   = 1'b1;
        t0      = cyc;
        @(negedge clock);
        start    = 1'b0;
        exp_addr = 0;
        stalls   = 0;
        reads    = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (bus.read) begin
                reads++;
                if (bus.waitrequest) begin
                    stalls++;
                    check("stall_addr", {31'd0, bus.address}, exp_addr);
                end else begin
                    exp_addr++;
                end
            end
            @(negedge clock);
        end
        check("stall_lat", cyc - t0, 32'd14);
        check("stall_cnt", stalls, 32'd6);
        check("stall_reads", reads, 32'd8);
        check("stall_pass", pass, 1'b1);
        check("stall_to", timeout, 1'b0);

        // Slave never returns data: timeout 16 cycles after RD_ID entry
        n_wait      = 0;
        lat         = 0;
        never_valid = 1'b1;
        start       = 1'b1;
        t0          = cyc;
        @(negedge clock);
        start = 1'b0;
        wait_done(60);
        check("to_lat", cyc - t0, 32'd17);
        check("to_flag", timeout, 1'b1);
        check("to_pass", pass, 1'b0);
        check("to_ok", {id_ok, ts_ok}, 32'd0);
        check("to_read", bus.read, 1'b0);

        // Valid arriving on the expiry cycle wins over the timeout
        never_valid = 1'b0;
        lat         = 15;
        start       = 1'b1;
        t0          = cyc;
        @(negedge clock);
        start = 1'b0;
        wait_done(80);
        check("edge_lat", cyc - t0, 32'd34);
        check("edge_to", timeout, 1'b0);
        check("edge_pass", pass, 1'b1);

        // Reset pulsed while waiting for the timestamp
        n_wait  = 3;
        lat     = 2;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        accepts = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.read && !bus.waitrequest) accepts++;
            @(negedge clock);
            if (accepts == 2 && !bus.read) break;
        end
        check("wt_ts_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_flags", flags(), 32'd0);
        check("mid_rst_id", id_value, 32'd0);
        check("mid_rst_ts", ts_value, 32'd0);
        reset = 1'b0;
        t0    = cyc;
        wait_done(60);
        check("rearm_lat", cyc - t0, 32'd14);
        check("rearm_pass", pass, 1'b1);

        // Start from DONE, then a start while busy must be ignored
        start = 1'b1;
        t0    = cyc;
        @(negedge clock);
        start   = 1'b0;
        entries = 0;
        prev    = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (bus.read && !bus.address && !prev) entries++;
            prev = bus.read && !bus.address;
            if (i == 3) begin
                check("busy_start", busy, 1'b1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check("one_run", entries, 32'd1);
        check("busy_lat", cyc - t0, 32'd14);
        check("busy_pass", pass, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
